// File: rtl/booth2_final_adder.sv
// booth2_final_adder
// Final carry-propagate adder behind the Booth-2 / 4:2 compressor tree of the
// 16x16 signed multiplier. It adds the redundant sum row and the carry row
// (the carry row is shifted left by 2) into the 32-bit product. The add is
// split into two registered 16-bit halves so no cycle carries a 32-bit ripple.
// Both sides use valid/ready. Stages collapse bubbles and hold one beat each.
module booth2_final_adder #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [31:0]      pp_sum,
  input  logic [29:0]      pp_carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] prod_cnt
);

  // Stage 1: low half already summed, upper operands kept for stage 2
  logic             s1_valid_q,    s1_valid_d;
  logic [15:0]      s1_lo_q,       s1_lo_d;
  logic             s1_c16_q,      s1_c16_d;
  logic [15:0]      s1_sum_hi_q,   s1_sum_hi_d;
  logic [15:0]      s1_carry_hi_q, s1_carry_hi_d;

  // Stage 2: the output register
  logic             out_valid_q,   out_valid_d;
  logic [31:0]      product_q,     product_d;
  logic [CNT_W-1:0] prod_cnt_q,    prod_cnt_d;

  // Handshake and datapath intermediates
  logic        s2_ready;
  logic        accept;
  logic        advance;
  logic        drain;
  logic [16:0] lo_sum;
  logic [15:0] hi_sum;

  // Handshake decode. in_ready depends combinationally on out_ready, so a
  // full pipeline that drains this cycle can still take a new beat.
  always_comb begin
    s2_ready = ~out_valid_q | out_ready;
    in_ready = sys_rst | ~s1_valid_q | s2_ready;
    accept   = in_valid & in_ready & ~sys_rst;
    advance  = s1_valid_q & s2_ready;
    drain    = out_valid_q & out_ready;
  end

  // The two 17-bit half adders. The carry row's two low bits are zero, so
  // only pp_carry[13:0] falls into the low half.
  always_comb begin
    lo_sum = {1'b0, pp_sum[15:0]} + {1'b0, pp_carry[13:0], 2'b00};
    hi_sum = s1_sum_hi_q + s1_carry_hi_q + {15'd0, s1_c16_q};
  end

  // Next state for both stages and the delivery counter. Every register holds
  // by default.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_c16_d      = s1_c16_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    out_valid_d   = out_valid_q;
    product_d     = product_q;
    prod_cnt_d    = prod_cnt_q;

    s1_valid_d = accept | (s1_valid_q & ~s2_ready);
    if (accept) begin
      s1_lo_d       = lo_sum[15:0];
      s1_c16_d      = lo_sum[16];
      s1_sum_hi_d   = pp_sum[31:16];
      s1_carry_hi_d = pp_carry[29:14];
    end

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (advance) begin
      product_d = {hi_sum, s1_lo_q};
    end

    if (drain) begin
      prod_cnt_d = prod_cnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset drops every in-flight beat and clears the data.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c16_q      <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      out_valid_q   <= 1'b0;
      product_q     <= '0;
      prod_cnt_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_c16_q      <= s1_c16_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      out_valid_q   <= out_valid_d;
      product_q     <= product_d;
      prod_cnt_q    <= prod_cnt_d;
    end
  end

  assign product   = product_q;
  assign out_valid = out_valid_q;
  assign prod_cnt  = prod_cnt_q;

endmodule

// File: doc/booth2_final_adder.md
# booth2_final_adder

Pipelined carry-propagate adder that follows the Booth-2 partial-product compressor in the 16×16 signed multiplier. It takes the two redundant rows left by the Wallace/4:2 tree, a 32-bit sum row and a 30-bit carry row with an implicit 2-bit left shift, and adds them into the final 32-bit two's-complement product. The add is split into two registered 16-bit halves with a valid/ready handshake on both sides, so the multiplier datapath can stall without losing or reordering products.

## Interface
- `CNT_W`, default 16: width of the delivered-product counter.

- `sys_clk`  in  1  sole clock; all state updates on the rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `pp_sum`  in  32  compressed sum row (bit k has weight 2^k).
- `pp_carry`  in  30  compressed carry row. Bit k has weight 2^(k+2); the two implied low bits are zero.
- `in_valid`  in  1  `pp_sum`/`pp_carry` carry a beat.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `product`  out  32  final product, two's complement.
- `out_valid`  out  1  `product` holds a beat.
- `out_ready`  in  1  downstream takes `product` this cycle.
- `prod_cnt`  out  `CNT_W`  number of products delivered since reset; wraps modulo 2^`CNT_W`.

## Operation
- Operand alignment: `addend_c = {pp_carry, 2'b00}` (32 bits). Result = `pp_sum + addend_c` mod 2^32. The carry out of bit 31 is discarded.
- Stage 1 (S1), loaded on input acceptance:
  - `s1_lo = pp_sum[15:0] + addend_c[15:0]`, a 17-bit result.
  - Register `s1_lo[15:0]` and the carry `s1_c16 = s1_lo[16]`.
  - Register the upper operands `pp_sum[31:16]` and `pp_carry[29:14]`.
  - Set `s1_valid`.
- Stage 2 (S2, the output register), loaded when S1 advances:
  - `product[31:16] = s1_sum_hi + s1_carry_hi + s1_c16` (mod 2^16).
  - `product[15:0] = s1_lo[15:0]`.
  - Set `out_valid`.
- Handshake (bubble-collapsing, one beat per stage):
  - `s2_ready = ~out_valid | out_ready`.
  - `in_ready = ~s1_valid | s2_ready`. This path is combinational from `out_ready`, and that is intentional.
  - An input beat is accepted when `in_valid & in_ready`.
  - S1 advances into S2 when `s1_valid & s2_ready`.
  - A beat leaves when `out_valid & out_ready`.
- Valid updates:
  - `s1_valid` next = `(in_valid & in_ready) | (s1_valid & ~s2_ready)`.
  - `out_valid` next = `s1_valid | (out_valid & ~out_ready)`, evaluated only when `s2_ready`; otherwise `out_valid` holds.
- Stall: while `out_valid & ~out_ready`, `product` and `out_valid` hold stable. S1 holds its contents, and `in_ready` = `~s1_valid`.
- Counter: `prod_cnt` increments by 1 on each edge where `out_valid & out_ready`. It wraps from 2^`CNT_W`−1 to 0.
- Simultaneous events: in the same cycle, a new input is accepted, S1 moves to S2, and S2 drains. The pipeline keeps full throughput, one product per cycle.
- Inputs are ignored while `in_ready` = 0. `pp_sum` and `pp_carry` are ignored while `in_valid` = 0.

## Timing
- Reset (`sys_rst` = 1 at an edge):
  - `s1_valid` = 0, `out_valid` = 0, `product` = 32'h0, `prod_cnt` = 0. S1 data registers clear to 0.
  - During reset `in_ready` evaluates to 1, but no beat is accepted.
- Reset mid-operation: all in-flight beats are dropped, with no partial output. The first beat after reset behaves as if from power-up.
- Latency: a beat accepted at edge N is in S1 after N and in S2 after N+1. `out_valid` = 1 in the cycle after edge N+1 (2 cycles), provided S2 was free.
- Throughput: 1 beat/cycle with `out_ready` held at 1.
- Critical path: one 17-bit adder per stage. There is no 32-bit ripple in any single cycle.

## Test plan
- Plain add:
  - `pp_sum` = 32'h3FFF_0001, `pp_carry` = 0 → `product` = 32'h3FFF_0001 two cycles after acceptance, `prod_cnt` = 1.
- Carry across the half boundary:
  - `pp_sum` = 32'h0000_FFFF, `pp_carry` = 30'h1 → `product` = 32'h0001_0003.
  - `pp_sum` = 32'h0000_FFFC, `pp_carry` = 30'h1 → `product` = 32'h0001_0000.
- Wrap-around:
  - `pp_sum` = 32'hFFFF_FFFF, `pp_carry` = 30'h3FFF_FFFF → `product` = 32'hFFFF_FFFB (carry out of bit 31 dropped).
  - Negative × positive, with rows from the compressor for −3×5 → `product` = 32'hFFFF_FFF1.
- Back-pressure: stream 4 beats A–D with `in_valid` = 1 and `out_ready` = 0 for 3 cycles.
  - `in_ready` falls after A reaches S2 and B reaches S1.
  - `product` = A stays stable.
  - When `out_ready` goes to 1, A, B, C, D emerge in order on consecutive cycles.
- Full throughput: 100 random rows with `out_ready` = 1 and `in_valid` = 1.
  - Each output equals `pp_sum + {pp_carry, 2'b00}` mod 2^32.
  - One output per cycle, `prod_cnt` = 100.
- Reset mid-stream: assert `sys_rst` for 1 cycle while both stages are full.
  - Next cycle: `out_valid` = 0, `prod_cnt` = 0, `product` = 0.
  - A fresh beat appears 2 cycles after acceptance.
  - With `CNT_W` = 4, 17 deliveries → `prod_cnt` = 1.
